// File: rtl/debug_pkg.sv
// Shared definitions for the debug-unit dump stream: receiver FSM encodings,
// word geometry and the word layout of a dump frame.
package debug_pkg;

  // Receiver FSM state encodings (also exposed on o_state).
  localparam logic [2:0] DU_RX_IDLE    = 3'd0;
  localparam logic [2:0] DU_RX_RECEIVE = 3'd1;
  localparam logic [2:0] DU_RX_COMMIT  = 3'd2;

  // UART bytes per dump word, least-significant byte first on the wire.
  localparam int BYTES_PER_WORD = 4;

  // Word positions inside a frame: PC, R0..R(N-1), DATA_MEM, CYCLES.
  localparam int IDX_PC       = 0;
  localparam int IDX_REG_BASE = 1;

  function automatic int frame_words(input int n_registers);
    return n_registers + 3;
  endfunction

  function automatic int idx_data_mem(input int n_registers);
    return n_registers + 1;
  endfunction

  function automatic int idx_cycles(input int n_registers);
    return n_registers + 2;
  endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART bytes into little-endian words. After the fourth
// byte of a word o_word holds the complete value and o_word_valid pulses for
// one cycle. i_flush drops any partially assembled word.
module uart_word_assembler
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid,
  output logic               o_partial
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [NB_DATA-1:0] shift_q;
  logic [1:0]         byte_cnt;
  logic               word_valid_q;

  // Shift each byte in from the top so byte k ends up in bits [8k+7:8k].
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_q      <= '0;
      byte_cnt     <= '0;
      word_valid_q <= 1'b0;
    end else if (i_flush) begin
      shift_q      <= '0;
      byte_cnt     <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= i_byte_valid && (byte_cnt == LAST_BYTE);
      if (i_byte_valid) begin
        shift_q  <= {i_byte, shift_q[NB_DATA-1:NB_BYTE]};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  assign o_word       = shift_q;
  assign o_word_valid = word_valid_q;
  assign o_partial    = (byte_cnt != 2'd0);

endmodule

// File: rtl/debug_dump_receiver.sv
// Receiving end of the debug-unit dump stream. Rebuilds 32-bit words from
// UART bytes, stores them in frame order in shadow storage and commits the
// whole frame (PC, registers, data-memory word, cycle count) to stable
// outputs only once the last word has arrived.
//
// Byte interface: i_rx_done is a one-cycle valid strobe that qualifies
// i_rx_data; there is no ready/back-pressure, so every strobed byte is
// consumed in the cycle it appears (unless i_clear drops it).
module debug_dump_receiver
  import debug_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_BYTE        = 8,
  parameter int N_REGISTERS    = 32,
  parameter int NB_STATE       = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NB_BYTE-1:0]             i_rx_data,
  input  logic                           i_rx_done,
  input  logic                           i_clear,
  output logic [NB_DATA-1:0]             o_pc,
  output logic [N_REGISTERS*NB_DATA-1:0] o_registers,
  output logic [NB_DATA-1:0]             o_data_memory,
  output logic [NB_DATA-1:0]             o_cycles,
  output logic                           o_frame_valid,
  output logic                           o_error,
  output logic                           o_busy,
  output logic [NB_STATE-1:0]            o_state
);

  localparam int FRAME_WORDS  = frame_words(N_REGISTERS);
  localparam int IDX_DATA_MEM = idx_data_mem(N_REGISTERS);
  localparam int IDX_CYCLES   = idx_cycles(N_REGISTERS);
  localparam int NB_WORD_IDX  = $clog2(FRAME_WORDS + 1);
  localparam int NB_TIMEOUT   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NB_WORD_IDX-1:0] LAST_WORD    = NB_WORD_IDX'(FRAME_WORDS - 1);
  localparam logic [NB_TIMEOUT-1:0]  TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_TIMEOUT-1:0]  TIMEOUT_MAX  = NB_TIMEOUT'(TIMEOUT_CYCLES);

  logic [NB_STATE-1:0]    state;
  logic [NB_STATE-1:0]    state_next;
  logic [NB_WORD_IDX-1:0] word_idx;
  logic [NB_TIMEOUT-1:0]  timeout_cnt;

  logic [FRAME_WORDS-1:0][NB_DATA-1:0] shadow;

  logic [NB_DATA-1:0] asm_word;
  logic               asm_word_valid;
  logic               asm_partial;
  logic               asm_flush;
  logic               timeout_hit;
  logic               last_word_done;

  // A byte landing on the timeout cycle resets the count instead of failing.
  assign timeout_hit    = (state == DU_RX_RECEIVE) && !i_clear && !i_rx_done &&
                          (timeout_cnt >= TIMEOUT_LAST);
  assign asm_flush      = i_clear || timeout_hit;
  assign last_word_done = (state == DU_RX_RECEIVE) && asm_word_valid &&
                          (word_idx == LAST_WORD);

  uart_word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_flush      (asm_flush),
    .i_byte_valid (i_rx_done),
    .i_byte       (i_rx_data),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid),
    .o_partial    (asm_partial)
  );

  // Next-state logic; i_clear overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      DU_RX_IDLE:    if (i_rx_done) state_next = DU_RX_RECEIVE;
      DU_RX_RECEIVE: begin
        if (timeout_hit)         state_next = DU_RX_IDLE;
        else if (last_word_done) state_next = DU_RX_COMMIT;
      end
      // Bytes of the next frame that already started keep the FSM receiving.
      DU_RX_COMMIT:  state_next = (i_rx_done || asm_partial) ? DU_RX_RECEIVE : DU_RX_IDLE;
      default:       state_next = DU_RX_IDLE;
    endcase
    if (i_clear) state_next = DU_RX_IDLE;
  end

  // State register, frame word index and saturating inter-byte timeout counter.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= DU_RX_IDLE;
      word_idx    <= '0;
      timeout_cnt <= '0;
    end else begin
      state <= state_next;
      if (i_clear || timeout_hit || state != DU_RX_RECEIVE)
        word_idx <= '0;
      else if (asm_word_valid && word_idx <= LAST_WORD)
        word_idx <= word_idx + NB_WORD_IDX'(1);
      if (i_clear || timeout_hit || i_rx_done || state != DU_RX_RECEIVE)
        timeout_cnt <= '0;
      else if (timeout_cnt != TIMEOUT_MAX)
        timeout_cnt <= timeout_cnt + NB_TIMEOUT'(1);
    end
  end

  // Shadow storage: completed words land in frame order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shadow <= '0;
    end else if (state == DU_RX_RECEIVE && asm_word_valid && !i_clear &&
                 word_idx <= LAST_WORD) begin
      shadow[word_idx] <= asm_word;
    end
  end

  // Commit registers: copied from shadow only in COMMIT; status pulses.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_pc          <= '0;
      o_registers   <= '0;
      o_data_memory <= '0;
      o_cycles      <= '0;
      o_frame_valid <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      o_error       <= timeout_hit;
      if (state == DU_RX_COMMIT && !i_clear) begin
        o_pc          <= shadow[IDX_PC];
        o_registers   <= shadow[IDX_REG_BASE +: N_REGISTERS];
        o_data_memory <= shadow[IDX_DATA_MEM];
        o_cycles      <= shadow[IDX_CYCLES];
        o_frame_valid <= 1'b1;
      end
    end
  end

  assign o_busy  = (state == DU_RX_RECEIVE);
  assign o_state = state;

endmodule

// File: tb/tb_debug_dump_receiver.sv
// Bench for debug_dump_receiver: directed scenario steps with randomized
// frame contents and inter-byte gaps, checked against a frame-level model.
module tb_debug_dump_receiver;

  localparam int NB_DATA  = 32;
  localparam int NB_BYTE  = 8;
  localparam int NREG     = 32;
  localparam int NB_STATE = 3;
  localparam int TMO      = 50;
  localparam int FW       = NREG + 3;
  localparam int FB       = FW * 4;

  // ---------------- clock / reset / DUT ----------------
  logic                      i_clock = 1'b0;
  logic                      i_reset = 1'b0;
  logic [NB_BYTE-1:0]        i_rx_data = '0;
  logic                      i_rx_done = 1'b0;
  logic                      i_clear = 1'b0;
  logic [NB_DATA-1:0]        o_pc;
  logic [NREG*NB_DATA-1:0]   o_registers;
  logic [NB_DATA-1:0]        o_data_memory;
  logic [NB_DATA-1:0]        o_cycles;
  logic                      o_frame_valid;
  logic                      o_error;
  logic                      o_busy;
  logic [NB_STATE-1:0]       o_state;

  always #5 i_clock = ~i_clock;

  debug_dump_receiver #(
    .NB_DATA        (NB_DATA),
    .NB_BYTE        (NB_BYTE),
    .N_REGISTERS    (NREG),
    .NB_STATE       (NB_STATE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .i_clear       (i_clear),
    .o_pc          (o_pc),
    .o_registers   (o_registers),
    .o_data_memory (o_data_memory),
    .o_cycles      (o_cycles),
    .o_frame_valid (o_frame_valid),
    .o_error       (o_error),
    .o_busy        (o_busy),
    .o_state       (o_state)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [NB_DATA-1:0] exp_q[$];          // words of the frame being sent
  logic [NB_DATA-1:0] m_pc, m_dm, m_cyc; // expected committed values
  logic [NB_DATA-1:0] m_regs[NREG];

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int err_count = 0;
  int both_count = 0;

  // Pulse counters, sampled at the clock edge (values of the ending cycle).
  always @(posedge i_clock) begin
    if (o_frame_valid) fv_count++;
    if (o_error) err_count++;
    if (o_frame_valid && o_error) both_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_dm = '0; m_cyc = '0;
    for (int r = 0; r < NREG; r++) m_regs[r] = '0;
  endtask

  task automatic commit_model();
    m_pc = exp_q[0];
    for (int r = 0; r < NREG; r++) m_regs[r] = exp_q[1 + r];
    m_dm  = exp_q[NREG + 1];
    m_cyc = exp_q[NREG + 2];
  endtask

  task automatic check_committed(input string tag);
    chk({tag, "_pc"}, o_pc, m_pc);
    for (int r = 0; r < NREG; r++)
      chk($sformatf("%s_r%0d", tag, r), o_registers[r*NB_DATA +: NB_DATA], m_regs[r]);
    chk({tag, "_dmem"}, o_data_memory, m_dm);
    chk({tag, "_cyc"}, o_cycles, m_cyc);
  endtask

  task automatic build_frame(input bit directed);
    exp_q.delete();
    for (int k = 0; k < FW; k++) begin
      if (!directed)            exp_q.push_back($urandom);
      else if (k == 0)          exp_q.push_back(32'h0040_0010);
      else if (k <= NREG)       exp_q.push_back(32'h1000_0000 + 32'(k - 1));
      else if (k == NREG + 1)   exp_q.push_back(32'hDEAD_BEEF);
      else                      exp_q.push_back(32'h0000_0123);
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
    repeat (gap) @(negedge i_clock);
  endtask

  // Sends frame bytes first..last (LSB first per word); the final byte of
  // the range has no trailing gap. slow_every>0 inserts a gap that puts the
  // next byte exactly on the timeout cycle.
  task automatic send_range(input int first, input int last, input int slow_every);
    for (int i = first; i <= last; i++) begin
      logic [NB_DATA-1:0] w;
      int gap;
      w   = exp_q[i / 4];
      gap = (i == last) ? 0 : int'($urandom_range(0, 3));
      if (slow_every > 0 && i != last && (i % slow_every) == slow_every - 1) gap = TMO - 1;
      send_byte(w[8*(i%4) +: 8], gap);
    end
  endtask

  // Called at the falling edge right after the final byte was sampled.
  task automatic finish_check(input string tag);
    @(negedge i_clock);
    chk({tag, "_fv_early"}, 32'(o_frame_valid), 32'd0);
    @(negedge i_clock);
    chk({tag, "_fv"}, 32'(o_frame_valid), 32'd1);
    commit_model();
    check_committed(tag);
    @(negedge i_clock);
    chk({tag, "_fv_end"}, 32'(o_frame_valid), 32'd0);
    chk({tag, "_idle"}, 32'(o_state), 32'd0);
  endtask

  // ---------------- directed steps ----------------
  initial begin
    int fv0, e0;

    // Reset state
    model_reset();
    repeat (3) @(negedge i_clock);
    check_committed("rst");
    chk("rst_fv", 32'(o_frame_valid), 32'd0);
    chk("rst_err", 32'(o_error), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clock);

    // Directed frame from the test plan
    build_frame(1'b1);
    send_range(0, FB - 1, 0);
    chk("dir_busy", 32'(o_busy), 32'd1);
    finish_check("dir");

    // Random frame
    build_frame(1'b0);
    send_range(0, FB - 1, 0);
    finish_check("rnd");

    // Back-to-back: first byte of frame B sampled during COMMIT of frame A
    fv0 = fv_count;
    build_frame(1'b0);
    send_range(0, FB - 1, 0);
    @(negedge i_clock);
    chk("b2b_commit_state", 32'(o_state), 32'd2);
    commit_model();
    build_frame(1'b0);
    send_byte(exp_q[0][7:0], 0);
    chk("b2b_a_fv", 32'(o_frame_valid), 32'd1);
    chk("b2b_recv_state", 32'(o_state), 32'd1);
    check_committed("b2b_a");
    send_range(1, FB - 1, 0);
    finish_check("b2b_b");
    chk("b2b_pulses", 32'(fv_count - fv0), 32'd2);

    // Timeout after 70 bytes
    e0 = err_count;
    build_frame(1'b0);
    send_range(0, 69, 0);
    repeat (TMO - 1) @(negedge i_clock);
    chk("tmo_err_early", 32'(o_error), 32'd0);
    chk("tmo_state_early", 32'(o_state), 32'd1);
    @(negedge i_clock);
    chk("tmo_err", 32'(o_error), 32'd1);
    chk("tmo_state", 32'(o_state), 32'd0);
    chk("tmo_busy", 32'(o_busy), 32'd0);
    @(negedge i_clock);
    chk("tmo_err_end", 32'(o_error), 32'd0);
    chk("tmo_err_count", 32'(err_count - e0), 32'd1);
    check_committed("tmo_keep");
    build_frame(1'b0);
    send_range(0, FB - 1, 0);
    finish_check("tmo_next");

    // Bytes arriving exactly on the timeout cycle
    e0 = err_count;
    build_frame(1'b0);
    send_range(0, FB - 1, 35);
    finish_check("exact");
    chk("exact_no_err", 32'(err_count - e0), 32'd0);

    // i_clear after 10 bytes, coinciding with an 11th byte
    e0 = err_count;
    build_frame(1'b0);
    send_range(0, 9, 0);
    i_clear = 1'b1;
    send_byte(exp_q[2][23:16], 0);
    i_clear = 1'b0;
    chk("clr_state", 32'(o_state), 32'd0);
    chk("clr_busy", 32'(o_busy), 32'd0);
    check_committed("clr_keep");
    repeat (TMO + 5) @(negedge i_clock);
    chk("clr_no_err", 32'(err_count - e0), 32'd0);
    chk("clr_idle", 32'(o_state), 32'd0);
    build_frame(1'b0);
    send_range(0, FB - 1, 0);
    finish_check("clr_next");

    // Asynchronous reset mid-frame, between clock edges
    build_frame(1'b0);
    send_range(0, 49, 0);
    #3 i_reset = 1'b0;
    #1;
    model_reset();
    check_committed("arst");
    chk("arst_fv", 32'(o_frame_valid), 32'd0);
    chk("arst_err", 32'(o_error), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_state", 32'(o_state), 32'd0);
    #8 i_reset = 1'b1;
    @(negedge i_clock);
    build_frame(1'b0);
    send_range(0, FB - 1, 0);
    finish_check("arst_next");

    chk("never_both", 32'(both_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
